r_ptr_empty: RTL and testbench
==============================

// Module: r_ptr_empty
// PURPOSE
//  Read-side pointer/status controller of the dual-clock FIFO; counterpart of the write-side pointer/full block.
//  Lives in the read clock domain. Advances the binary read pointer and exports it as Gray code for the
//  write-domain synchronizer. Derives empty, almost-empty, fill level and a sticky underflow flag from the
//  2-flop-synchronized write pointer. Drives the dual-port RAM read address.
// PARAMETERS
//  ADDRSIZE   4  RAM address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits (wrap bit)
//  AE_THRESH  2  ralmost_empty asserts when registered fill level <= AE_THRESH (0..2**ADDRSIZE)
// PORTS
//  rclk          in   1           read-domain clock, all state on posedge
//  rrst_n        in   1           async active-low reset (assert async, release sync to rclk upstream)
//  rinc          in   1           read request; honoured only when rempty==0
//  rq2_wptr      in   ADDRSIZE+1  write pointer, Gray, already 2-flop synchronized into rclk
//  rerr_clr      in   1           clears sticky rerr
//  rempty        out  1           FIFO empty (registered)
//  ralmost_empty out  1           fill level <= AE_THRESH (registered)
//  raddr         out  ADDRSIZE    RAM read address = rbin[ADDRSIZE-1:0]; head entry
//  rptr          out  ADDRSIZE+1  read pointer, Gray, registered (to write-domain sync)
//  rlevel        out  ADDRSIZE+1  entries present, binary, 0..2**ADDRSIZE (registered)
//  rerr          out  1           sticky underflow: rinc seen while rempty==1
// BEHAVIOUR
//  - Reset (rrst_n=0, async): rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, rerr=0.
//  - rbinnext = rbin + (rinc & ~rempty), modulo 2**(ADDRSIZE+1); rgraynext = (rbinnext>>1) ^ rbinnext.
//  - Every posedge: {rbin, rptr} <= {rbinnext, rgraynext}; raddr follows rbin, i.e. 1 cycle after rinc.
//  - rempty <= (rgraynext == rq2_wptr); full Gray compare incl. MSB, no MSB inversion (that is the full rule).
//  - wq2_bin = gray2bin(rq2_wptr); rlevel <= wq2_bin - rbinnext (ADDRSIZE+1-bit unsigned, wrap-safe).
//  - ralmost_empty <= (wq2_bin - rbinnext) <= AE_THRESH; consistent with rempty (rempty => ralmost_empty).
//  - Read data valid at raddr while rempty==0; consumer samples data and pulses rinc in the same cycle.
//  - Latency: rinc taking the last entry -> rempty=1 on next edge. New write -> rempty=0 one rclk after
//    rq2_wptr changes (2-3 rclk after wptr leaves write domain). Empty/level are pessimistic, never optimistic.
//  - rinc while rempty==1: pointers unchanged, rempty stays 1, rerr <= 1 next edge.
//  - rerr: set has priority over rerr_clr in the same cycle; otherwise rerr_clr clears it next edge.
//  - rinc and rq2_wptr change in the same cycle: both folded into next-state; no missed or double count.
//  - Wrap: rbin 2**(ADDRSIZE+1)-1 -> 0; MSB toggles each pass over the RAM; raddr wraps 2**ADDRSIZE-1 -> 0.
//  - rq2_wptr assumed single-bit-change per rclk (Gray + synchronizer); multi-bit jumps need not be tolerated.
//  - Reset mid-operation: all outputs return to reset values immediately, independent of rclk.
// STRUCTURE
//  - Shared include fifo_defs.vh: default ADDRSIZE, bin2gray/gray2bin functions (also used by write side).
//  - One natural sub-module: gray2bin (combinational, parameterised width) for rq2_wptr decode.
//  - Single always block per register group; no FSM beyond pointer + flags.
// TESTING  (ADDRSIZE=4, AE_THRESH=2)
//  1 Reset: assert rrst_n=0 mid-clock -> immediately rempty=1, ralmost_empty=1, rptr=0, raddr=0, rlevel=0, rerr=0.
//  2 Fill: rq2_wptr=00001 (bin 1) -> next edge rempty=0, rlevel=1, ralmost_empty=1; step to gray(3)=00010
//    -> rlevel=3, ralmost_empty=0.
//  3 Drain: with level 1, pulse rinc -> next edge rptr=00001, raddr=1, rempty=1, rlevel=0.
//  4 Wrap: rq2_wptr=gray(16)=11000, 16 consecutive rinc -> rlevel 16..0, rptr=11000, raddr=0, rempty=1;
//    second full pass returns rptr to 00000.
//  5 Underflow: rinc=1 while empty -> rptr unchanged, rerr=1 next edge and held; rerr_clr=1 -> rerr=0;
//    rinc on empty with rerr_clr same cycle -> rerr=1.
//  6 Concurrent: level 2, rinc=1 same cycle rq2_wptr advances by 1 -> rlevel=2, rempty=0, raddr+1.

Source files
------------

// File: rtl/r_ptr_empty_pkg.sv
// +--------------------------------------------------------------------------+
// | r_ptr_empty_pkg : shared defaults for the dual-clock FIFO pointer blocks  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package r_ptr_empty_pkg;

  localparam int C_ADDRSIZE_DEFAULT  = 4;
  localparam int C_AE_THRESH_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/r_ptr_empty_gray2bin.sv
// +--------------------------------------------------------------------------+
// | r_ptr_empty_gray2bin : combinational Gray-to-binary decoder               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module r_ptr_empty_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/r_ptr_empty.sv
// +--------------------------------------------------------------------------+
// | r_ptr_empty : read-side pointer and empty/level/underflow status of the   |
// | dual-clock FIFO, living entirely in the read clock domain.                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module r_ptr_empty
  import r_ptr_empty_pkg::*;
#(
  parameter int ADDRSIZE  = C_ADDRSIZE_DEFAULT,
  parameter int AE_THRESH = C_AE_THRESH_DEFAULT
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                rerr_clr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rerr
);

  localparam int C_PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rempty;
  logic              r_ralmost_empty;
  logic [ADDRSIZE:0] r_rlevel;
  logic              r_rerr;

  logic              w_take;
  logic [ADDRSIZE:0] w_rbinnext;
  logic [ADDRSIZE:0] w_rgraynext;
  logic [ADDRSIZE:0] w_wq2_bin;
  logic [ADDRSIZE:0] w_level_next;

  r_ptr_empty_gray2bin #(
    .WIDTH (C_PW)
  ) u_wq2_dec (
    .gray (rq2_wptr),
    .bin  (w_wq2_bin)
  );

  assign w_take       = rinc & ~r_rempty;
  assign w_rbinnext   = r_rbin + {{ADDRSIZE{1'b0}}, w_take};
  assign w_rgraynext  = (w_rbinnext >> 1) ^ w_rbinnext;
  // Modular subtraction stays correct across pointer wrap via the extra MSB.
  assign w_level_next = w_wq2_bin - w_rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin <= '0;
      r_rptr <= '0;
    end else begin
      r_rbin <= w_rbinnext;
      r_rptr <= w_rgraynext;
    end
  end

  // Status is computed from the lagging synchronized write pointer, so it can
  // only under-report the fill level, never over-report it.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
      r_rlevel        <= '0;
    end else begin
      r_rempty        <= (w_rgraynext == rq2_wptr);
      r_ralmost_empty <= (w_level_next <= C_PW'(AE_THRESH));
      r_rlevel        <= w_level_next;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rerr <= 1'b0;
    end else if (rinc && r_rempty) begin
      r_rerr <= 1'b1;
    end else if (rerr_clr) begin
      r_rerr <= 1'b0;
    end
  end

  assign rempty        = r_rempty;
  assign ralmost_empty = r_ralmost_empty;
  assign raddr         = r_rbin[ADDRSIZE-1:0];
  assign rptr          = r_rptr;
  assign rlevel        = r_rlevel;
  assign rerr          = r_rerr;

endmodule

`default_nettype wire

// File: tb/tb_r_ptr_empty.sv
// +--------------------------------------------------------------------------+
// | tb_r_ptr_empty : self-checking bench for r_ptr_empty with a counting     |
// | FIFO-occupancy reference model. Rev 1.0                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_r_ptr_empty;

  localparam int ADDRSIZE  = 4;
  localparam int AE_THRESH = 2;
  localparam int DEPTH     = 1 << ADDRSIZE;
  localparam int PMOD      = 2 * DEPTH;

  logic                rclk = 1'b0;
  logic                rrst_n;
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic                rerr_clr;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   rlevel;
  logic                rerr;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: entries read and written counted modulo twice the depth.
  int m_rd;
  int m_wr;
  bit m_empty;
  bit m_err;

  r_ptr_empty #(
    .ADDRSIZE  (ADDRSIZE),
    .AE_THRESH (AE_THRESH)
  ) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rerr_clr      (rerr_clr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .raddr         (raddr),
    .rptr          (rptr),
    .rlevel        (rlevel),
    .rerr          (rerr)
  );

  always #5 rclk = ~rclk;

  function automatic logic [ADDRSIZE:0] to_gray(input int v);
    logic [ADDRSIZE:0] b;
    b = v[ADDRSIZE:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int m_level();
    return (m_wr - m_rd + PMOD) % PMOD;
  endfunction

  function automatic logic [16:0] exp_vec();
    int lvl;
    lvl = m_level();
    return {m_empty, (lvl <= AE_THRESH), 4'(m_rd % DEPTH), to_gray(m_rd), 5'(lvl), m_err};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {rempty, ralmost_empty, raddr, rptr, rlevel, rerr};
  endfunction

  // One rclk cycle: inputs are set just after an edge, model follows the edge.
  task automatic step(input bit inc, input bit wadv, input bit clr);
    int nwr;
    nwr      = (m_wr + (wadv ? 1 : 0)) % PMOD;
    rinc     = inc;
    rerr_clr = clr;
    rq2_wptr = to_gray(nwr);
    @(posedge rclk);
    #1;
    if (inc && m_empty)  m_err = 1'b1;
    else if (clr)        m_err = 1'b0;
    if (inc && !m_empty) m_rd = (m_rd + 1) % PMOD;
    m_wr    = nwr;
    m_empty = (m_wr == m_rd);
    rinc     = 1'b0;
    rerr_clr = 1'b0;
  endtask

  task automatic apply_reset();
    #3;
    rrst_n   = 1'b0;
    rq2_wptr = '0;
    rinc     = 1'b0;
    rerr_clr = 1'b0;
    m_rd = 0; m_wr = 0; m_empty = 1'b1; m_err = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    apply_reset();
    n_vec++;
    if (obs_vec() !== 17'h10001 << 0 && obs_vec() !== {1'b1, 1'b1, 15'd0}) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h", obs_vec(), {1'b1, 1'b1, 15'd0});
    end
    release_reset();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    step(1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({rempty, rlevel, ralmost_empty} !== {1'b0, 5'd1, 1'b1}) begin
      n_err++; $display("FAIL fill_level1: got %b want %b", {rempty, rlevel, ralmost_empty}, {1'b0, 5'd1, 1'b1});
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({rempty, rlevel, ralmost_empty} !== {1'b0, 5'd3, 1'b0}) begin
      n_err++; $display("FAIL fill_level3: got %b want %b", {rempty, rlevel, ralmost_empty}, {1'b0, 5'd3, 1'b0});
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL fill_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_drain();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL drain_to1: got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({rempty, rlevel, raddr, rptr} !== {1'b1, 5'd0, 4'd3, 5'b00010}) begin
      n_err++; $display("FAIL drain_last: got %b want %b", {rempty, rlevel, raddr, rptr}, {1'b1, 5'd0, 4'd3, 5'b00010});
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    release_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({rempty, ralmost_empty, rlevel} !== {1'b0, 1'b0, 5'd16}) begin
        n_err++; $display("FAIL wrap_full p%0d: got %b want %b", pass, {rempty, ralmost_empty, rlevel}, {1'b0, 1'b0, 5'd16});
      end
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
          n_err++; $display("FAIL wrap_read p%0d i%0d: got %h want %h", pass, i, obs_vec(), exp_vec());
        end
      end
      n_vec++;
      if ({rptr, raddr, rempty} !== {(pass == 0) ? 5'b11000 : 5'b00000, 4'd0, 1'b1}) begin
        n_err++; $display("FAIL wrap_end p%0d: got %b want %b", pass, {rptr, raddr, rempty},
                          {(pass == 0) ? 5'b11000 : 5'b00000, 4'd0, 1'b1});
      end
    end
  endtask

  task automatic test_underflow();
    logic [ADDRSIZE:0] p0;
    p0 = rptr;
    step(1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({rerr, rempty, rptr} !== {1'b1, 1'b1, p0}) begin
      n_err++; $display("FAIL underflow_set: got %b want %b", {rerr, rempty, rptr}, {1'b1, 1'b1, p0});
    end
    step(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (rerr !== 1'b1) begin
      n_err++; $display("FAIL underflow_hold: got %b want 1", rerr);
    end
    step(1'b0, 1'b0, 1'b1);
    n_vec++;
    if (rerr !== 1'b0) begin
      n_err++; $display("FAIL underflow_clr: got %b want 0", rerr);
    end
    step(1'b1, 1'b0, 1'b1);
    n_vec++;
    if (rerr !== 1'b1) begin
      n_err++; $display("FAIL underflow_set_prio: got %b want 1", rerr);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_concurrent();
    logic [ADDRSIZE-1:0] a0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    a0 = raddr;
    step(1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({rlevel, rempty, raddr} !== {5'd2, 1'b0, a0 + 4'd1}) begin
      n_err++; $display("FAIL concurrent: got %b want %b", {rlevel, rempty, raddr}, {5'd2, 1'b0, a0 + 4'd1});
    end
  endtask

  task automatic test_random();
    bit inc, wadv, clr;
    for (int i = 0; i < 400; i++) begin
      inc  = ($urandom_range(0, 99) < 50);
      wadv = ($urandom_range(0, 99) < 50) && (m_level() < DEPTH);
      clr  = ($urandom_range(0, 99) < 10);
      step(inc, wadv, clr);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rrst_n   = 1'b0;
    rinc     = 1'b0;
    rerr_clr = 1'b0;
    rq2_wptr = '0;
    m_rd = 0; m_wr = 0; m_empty = 1'b1; m_err = 1'b0;
    release_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_underflow();
    test_concurrent();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
